jump_pc_unit: RTL and testbench

JUMP_PC_UNIT -- requirements
Module: jump_pc_unit

---
 rtl/jump_pc_unit.sv | 118 +++++++++++
 tb/tb_jump_pc_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jump_pc_unit.sv
// Program-counter unit: sequential, absolute, label-table and relative-branch next-PC sources,
// with a sticky halt and a saturating jump counter. Define JUMP_LUT_WRITE_EN to make the label table writable.
module jump_pc_unit #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 4,
  parameter int OFS_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic [1:0]       mode,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  target_in,
  input  logic [IDX_W-1:0] idx,
  input  logic [OFS_W-1:0] offset,
  input  logic             halt_req,
`ifdef JUMP_LUT_WRITE_EN
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_widx,
  input  logic [PC_W-1:0]  lut_wdata,
`endif
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [7:0]       jump_cnt
);

  typedef enum logic [1:0] {
    MODE_SEQ = 2'b00,
    MODE_ABS = 2'b01,
    MODE_TBL = 2'b10,
    MODE_REL = 2'b11
  } mode_e;

  function automatic logic [PC_W-1:0] default_label(input int unsigned i);
    logic [31:0] v;
    case (i)
      0:       v = 32'd10;
      1:       v = 32'd22;
      2:       v = 32'd76;
      3:       v = 32'd101;
      4:       v = 32'd123;
      5:       v = 32'd131;
      6:       v = 32'd8;
      7:       v = 32'd37;
      8:       v = 32'd16;
      default: v = '0;
    endcase
    return PC_W'(v);
  endfunction

  logic [PC_W-1:0] label_rd;

`ifdef JUMP_LUT_WRITE_EN
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [PC_W-1:0] label [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        label[IDX_W'(i)] <= default_label(i);
    end else if (lut_we) begin
      label[lut_widx] <= lut_wdata;
    end
  end

  // Read happens before the edge, so a same-cycle write is seen only from the next cycle.
  assign label_rd = label[idx];
`else
  assign label_rd = default_label(32'(idx));
`endif

  logic [PC_W-1:0] ofs_ext;
  logic [PC_W-1:0] next_pc;
  logic            is_jump;
  logic            upd;

  assign ofs_ext = PC_W'($signed(offset));
  assign upd     = advance & ~halted;

  always_comb begin
    next_pc = pc + PC_W'(1);
    is_jump = 1'b0;
    case (mode_e'(mode))
      MODE_SEQ: next_pc = pc + PC_W'(1);
      MODE_ABS: begin
        next_pc = target_in;
        is_jump = 1'b1;
      end
      MODE_TBL: begin
        next_pc = label_rd;
        is_jump = 1'b1;
      end
      MODE_REL: begin
        if (br_taken) begin
          next_pc = pc + ofs_ext;
          is_jump = 1'b1;
        end
      end
      default: next_pc = pc + PC_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      halted   <= 1'b0;
      jump_cnt <= '0;
    end else if (upd) begin
      pc <= next_pc;
      if (halt_req)
        halted <= 1'b1;
      if (is_jump && jump_cnt != 8'hFF)
        jump_cnt <= jump_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_jump_pc_unit.sv
// Directed self-checking bench for jump_pc_unit; the table-write section is compiled when
// JUMP_LUT_WRITE_EN is defined.
module tb_jump_pc_unit;
  localparam int PC_W  = 16;
  localparam int IDX_W = 4;
  localparam int OFS_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             advance;
  logic [1:0]       mode;
  logic             br_taken;
  logic [PC_W-1:0]  target_in;
  logic [IDX_W-1:0] idx;
  logic [OFS_W-1:0] offset;
  logic             halt_req;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic [7:0]       jump_cnt;
`ifdef JUMP_LUT_WRITE_EN
  logic             lut_we;
  logic [IDX_W-1:0] lut_widx;
  logic [PC_W-1:0]  lut_wdata;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_lbl [16] = '{16'd10, 16'd22, 16'd76, 16'd101, 16'd123, 16'd131, 16'd8, 16'd37,
                                16'd16, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

  always #5 clk = ~clk;

  jump_pc_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .OFS_W(OFS_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .mode      (mode),
    .br_taken  (br_taken),
    .target_in (target_in),
    .idx       (idx),
    .offset    (offset),
    .halt_req  (halt_req),
`ifdef JUMP_LUT_WRITE_EN
    .lut_we    (lut_we),
    .lut_widx  (lut_widx),
    .lut_wdata (lut_wdata),
`endif
    .pc        (pc),
    .halted    (halted),
    .jump_cnt  (jump_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset     = 1'b0;
    advance   = 1'b0;
    mode      = 2'b00;
    br_taken  = 1'b0;
    target_in = '0;
    idx       = '0;
    offset    = '0;
    halt_req  = 1'b0;
`ifdef JUMP_LUT_WRITE_EN
    lut_we    = 1'b0;
    lut_widx  = '0;
    lut_wdata = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic go(input logic [1:0] m);
    advance = 1'b1;
    mode    = m;
    tick();
    advance = 1'b0;
  endtask

  initial begin
    idle();
    tick();

    // reset overrides advance/halt_req in the same cycle
    reset = 1'b1; advance = 1'b1; halt_req = 1'b1; mode = 2'b01; target_in = 16'd77;
    tick();
    idle();
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", jump_cnt, 0);

    go(2'b00); check("seq1", pc, 1);
    go(2'b00); check("seq2", pc, 2);
    go(2'b00); check("seq3", pc, 3);
    check("seq_cnt", jump_cnt, 0);

    tick(); check("hold_noadv", pc, 3);

    // table jump from pc=5
    go(2'b00); go(2'b00);
    check("pc5", pc, 5);
    idx = 4'd2; go(2'b10);
    check("tbl2", pc, 76);
    check("tbl2_cnt", jump_cnt, 1);
    idx = 4'd12; go(2'b10);
    check("tbl12", pc, 0);
    check("tbl12_cnt", jump_cnt, 2);

    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      go(2'b10);
      check($sformatf("lbl%0d", i), pc, {16'd0, exp_lbl[i]});
    end

    // relative branch, taken with negative offset wraps below zero
    do_reset();
    repeat (4) go(2'b00);
    offset = 8'hFA; br_taken = 1'b1; go(2'b11);
    check("rel_neg", pc, 16'hFFFE);
    check("rel_neg_cnt", jump_cnt, 1);
    offset = 8'h05; go(2'b11);
    check("rel_pos_wrap", pc, 16'h0003);

    do_reset();
    repeat (4) go(2'b00);
    offset = 8'hFA; br_taken = 1'b0; go(2'b11);
    check("rel_nt", pc, 5);
    check("rel_nt_cnt", jump_cnt, 0);

    // sequential wrap at all-ones
    target_in = 16'hFFFF; go(2'b01);
    check("abs_ffff", pc, 16'hFFFF);
    go(2'b00);
    check("seq_wrap", pc, 0);
    check("wrap_cnt", jump_cnt, 1);

    // halt
    do_reset();
    halt_req = 1'b1; tick();
    check("halt_noadv", halted, 0);
    target_in = 16'd200; go(2'b01); halt_req = 1'b0;
    check("halt_pc", pc, 200);
    check("halt_flag", halted, 1);
    check("halt_cnt", jump_cnt, 1);
    go(2'b00); target_in = 16'd9; go(2'b01);
    check("halted_pc", pc, 200);
    check("halted_cnt", jump_cnt, 1);
    do_reset();
    check("unhalt", halted, 0);
    go(2'b00);
    check("unhalt_pc", pc, 1);

    // saturation
    do_reset();
    for (int i = 0; i < 254; i++) begin
      target_in = 16'(i); go(2'b01);
    end
    check("cnt254", jump_cnt, 254);
    go(2'b01);
    check("cnt255", jump_cnt, 255);
    for (int i = 0; i < 45; i++) begin
      target_in = 16'(i + 1000); go(2'b01);
    end
    check("cnt_sat", jump_cnt, 255);
    check("sat_pc", pc, 1044);

`ifdef JUMP_LUT_WRITE_EN
    do_reset();
    lut_we = 1'b1; lut_widx = 4'd3; lut_wdata = 16'd500; idx = 4'd3;
    go(2'b10);
    lut_we = 1'b0;
    check("wr_same", pc, 101);
    go(2'b10);
    check("wr_next", pc, 500);
    do_reset();
    idx = 4'd3; go(2'b10);
    check("wr_rst", pc, 101);
    reset = 1'b1; lut_we = 1'b1; lut_widx = 4'd4; lut_wdata = 16'd999;
    tick();
    idle();
    idx = 4'd4; go(2'b10);
    check("wr_blocked", pc, 123);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
